// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared operand, instruction and executor state types plus the single-cycle ALU
package instr_register_pkg;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0] address_t;
  typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EXEC, DIVIDE, OUTPUT, DONE} exec_state_t;
  function automatic logic is_div(opcode_t o);
    return o == DIV || o == MOD;
  endfunction
  function automatic result_t alu(instruction_t i);
    result_t a, b;
    a = result_t'(i.op_a);
    b = result_t'(i.op_b);
    case (i.opc)
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/instr_executor_if.sv
// tb_ifc: burst command, instruction-register read port and result handshake
interface tb_ifc #(parameter int COUNT_W = 6);
  import instr_register_pkg::*;
  logic               start;
  address_t           first_addr;
  logic [COUNT_W-1:0] count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic               res_valid;
  logic               res_ready;
  result_t            result;
  address_t           res_addr;
  logic               div_err;
  logic               busy;
  logic               done;
  modport master(input start, first_addr, count, instruction_word, res_ready,
                 output read_pointer, res_valid, result, res_addr, div_err, busy, done);
  modport slave(output start, first_addr, count, instruction_word, res_ready,
                input read_pointer, res_valid, result, res_addr, div_err, busy, done);
endinterface

// File: rtl/instr_executor_divider.sv
// seq_divider: 32-step restoring signed divider, quotient truncates toward zero
module seq_divider
  import instr_register_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  operand_t a,
  input  operand_t b,
  output result_t  quotient,
  output result_t  remainder,
  output logic     done
);
  logic [31:0] r_q, r_rem, r_b;
  logic [5:0]  r_cnt;
  logic        r_qneg, r_rneg;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;
  logic [63:0] w_qmag, w_rmag;
  assign w_shift = {r_rem, r_q[31]};
  assign w_ge = w_shift >= {1'b0, r_b};
  assign w_diff = w_shift[31:0] - r_b;
  assign w_qmag = {32'b0, r_q};
  assign w_rmag = {32'b0, r_rem};
  assign quotient = r_qneg ? -$signed(w_qmag) : $signed(w_qmag);
  assign remainder = r_rneg ? -$signed(w_rmag) : $signed(w_rmag);
  // high while the final iteration is being performed, so results are settled next cycle
  assign done = r_cnt == 6'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (start) begin
      r_q    <= a[31] ? 32'(-a) : 32'(a);
      r_b    <= b[31] ? 32'(-b) : 32'(b);
      r_rem  <= '0;
      r_cnt  <= 6'd32;
      r_qneg <= a[31] ^ b[31];
      r_rneg <= a[31];
    end else if (r_cnt != 0) begin
      r_rem <= w_ge ? w_diff : w_shift[31:0];
      r_q   <= {r_q[30:0], w_ge};
      r_cnt <= r_cnt - 6'd1;
    end
  end
endmodule

// File: rtl/instr_executor.sv
// instr_executor: walks instruction-register entries, executes each and hands results out on valid/ready
module instr_executor
  import instr_register_pkg::*;
#(parameter int COUNT_W = 6)
(
  input logic clk,
  input logic reset,
  tb_ifc.master bus
);
  exec_state_t        r_state, w_next;
  address_t           r_ptr;
  logic [COUNT_W-1:0] r_remaining;
  instruction_t       r_instr;
  result_t            r_result;
  logic               r_div_err, r_use_div;
  logic               w_div_start, w_div_done, w_is_div, w_b_zero;
  result_t            w_quo, w_rem;
  assign w_is_div = is_div(r_instr.opc);
  assign w_b_zero = r_instr.op_b == 0;
  seq_divider u_div (
    .clk(clk), .reset(reset), .start(w_div_start), .a(r_instr.op_a), .b(r_instr.op_b),
    .quotient(w_quo), .remainder(w_rem), .done(w_div_done)
  );
  always_comb begin
    w_next = r_state;
    w_div_start = 1'b0;
    case (r_state)
      IDLE:    if (bus.start) w_next = bus.count == 0 ? DONE : FETCH;
      FETCH:   w_next = CAPTURE;
      CAPTURE: w_next = EXEC;
      EXEC: begin
        w_div_start = w_is_div && !w_b_zero;
        w_next = w_div_start ? DIVIDE : OUTPUT;
      end
      DIVIDE:  if (w_div_done) w_next = OUTPUT;
      OUTPUT:  if (bus.res_ready) w_next = r_remaining == 1 ? DONE : FETCH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_instr     <= '0;
      r_result    <= '0;
      r_div_err   <= 1'b0;
      r_use_div   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_ptr       <= bus.first_addr;
        r_remaining <= bus.count;
      end
      if (r_state == CAPTURE) r_instr <= bus.instruction_word;
      if (r_state == EXEC) begin
        r_result  <= alu(r_instr);
        r_div_err <= w_is_div && w_b_zero;
        r_use_div <= w_is_div && !w_b_zero;
      end
      if (r_state == OUTPUT && bus.res_ready) begin
        r_ptr       <= r_ptr + 5'd1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end
  // the divider holds its outputs once finished, so divide results are read straight from it
  assign bus.result = r_use_div ? (r_instr.opc == MOD ? w_rem : w_quo) : r_result;
  assign bus.read_pointer = r_state == FETCH ? r_ptr : '0;
  assign bus.res_valid = r_state == OUTPUT;
  assign bus.res_addr = r_ptr;
  assign bus.div_err = r_div_err;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
endmodule
